// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries FIELDS payload fields of WIDTH bits plus a valid bit. Flush and
// stall come from the hazard unit. On a stall the stage either holds its
// contents (STALL_MODE=0) or loads a bubble (STALL_MODE=1). Two saturating
// counters record stalled cycles and bubble loads for performance debug.
// The reset port is named "reset" but is asynchronous and active-low.
module pipe_stage_reg #(
  parameter int WIDTH      = 32,
  parameter int FIELDS     = 6,
  parameter int STALL_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    clear_stats,
  input  logic                    valid_i,
  input  logic [FIELDS*WIDTH-1:0] data_i,
  output logic                    valid_o,
  output logic [FIELDS*WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam int DW = FIELDS * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic          bubbleLoad;
  logic          stallEdge;

  // Next slot contents: flush, then stall, then a normal load; invalid slots become zeroed bubbles.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    bubbleLoad = 1'b0;
    if (flush) begin
      valid_d    = 1'b0;
      data_d     = '0;
      bubbleLoad = 1'b1;
    end else if (stall) begin
      if (STALL_MODE == 1) begin
        valid_d    = 1'b0;
        data_d     = '0;
        bubbleLoad = 1'b1;
      end
    end else if (valid_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else begin
      valid_d    = 1'b0;
      data_d     = '0;
      bubbleLoad = 1'b1;
    end
  end

  // Statistics: a stalled edge is one where flush did not take priority; clear_stats overrides increments.
  always_comb begin
    stallEdge    = stall & ~flush;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (clear_stats) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stallEdge && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (bubbleLoad && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two instances sharing stimulus, one per stall mode
// (hold-mode with a narrow 4-bit counter, bubble-mode with 16-bit counters),
// checked each cycle against a rule-based reference model.
module tb_pipe_stage_reg;

  localparam int WIDTH  = 32;
  localparam int FIELDS = 6;
  localparam int DW     = WIDTH * FIELDS;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          clearStats;
  logic          validIn;
  logic [DW-1:0] dataIn;

  logic          valid0, valid1;
  logic [DW-1:0] data0, data1;
  logic [3:0]    stallCnt0, bubbleCnt0;
  logic [15:0]   stallCnt1, bubbleCnt1;

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = hold-mode instance, 1 = bubble-mode instance.
  bit            expValid[2];
  logic [DW-1:0] expData[2];
  int            expStall[2];
  int            expBubble[2];
  int            maxCnt[2] = '{15, 65535};
  int            modeOf[2] = '{0, 1};

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(WIDTH), .FIELDS(FIELDS), .STALL_MODE(0), .CNT_W(4)) dutHold (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clear_stats(clearStats),
    .valid_i(validIn), .data_i(dataIn), .valid_o(valid0), .data_o(data0),
    .stall_cnt(stallCnt0), .bubble_cnt(bubbleCnt0)
  );

  pipe_stage_reg #(.WIDTH(WIDTH), .FIELDS(FIELDS), .STALL_MODE(1), .CNT_W(16)) dutBubble (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clear_stats(clearStats),
    .valid_i(validIn), .data_i(dataIn), .valid_o(valid1), .data_o(data1),
    .stall_cnt(stallCnt1), .bubble_cnt(bubbleCnt1)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic c, input logic v, input logic [DW-1:0] d);
    stall      = s;
    flush      = f;
    clearStats = c;
    validIn    = v;
    dataIn     = d;
  endtask

  function automatic logic [DW-1:0] randPayload();
    logic [DW-1:0] p;
    for (int k = 0; k < FIELDS; k++) p[k*WIDTH +: WIDTH] = $urandom;
    return p;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      expValid[m]  = 1'b0;
      expData[m]   = '0;
      expStall[m]  = 0;
      expBubble[m] = 0;
    end
  endtask

  // Apply the per-edge rules to the model using the inputs present at the edge.
  task automatic modelStep();
    bit isBubble;
    if (!reset) begin
      modelReset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      isBubble = 1'b0;
      if (flush) begin
        expValid[m] = 1'b0; expData[m] = '0; isBubble = 1'b1;
      end else if (stall) begin
        if (modeOf[m] == 1) begin
          expValid[m] = 1'b0; expData[m] = '0; isBubble = 1'b1;
        end
      end else if (validIn) begin
        expValid[m] = 1'b1; expData[m] = dataIn;
      end else begin
        expValid[m] = 1'b0; expData[m] = '0; isBubble = 1'b1;
      end
      if (clearStats) begin
        expStall[m]  = 0;
        expBubble[m] = 0;
      end else begin
        if (stall && !flush && expStall[m] < maxCnt[m]) expStall[m]++;
        if (isBubble && expBubble[m] < maxCnt[m]) expBubble[m]++;
      end
    end
  endtask

  task automatic checkAll(input string phase);
    checkOutput({phase, ".valid0"},  valid0,     expValid[0]);
    checkOutput({phase, ".data0"},   data0,      expData[0]);
    checkOutput({phase, ".stall0"},  stallCnt0,  expStall[0]);
    checkOutput({phase, ".bubble0"}, bubbleCnt0, expBubble[0]);
    checkOutput({phase, ".valid1"},  valid1,     expValid[1]);
    checkOutput({phase, ".data1"},   data1,      expData[1]);
    checkOutput({phase, ".stall1"},  stallCnt1,  expStall[1]);
    checkOutput({phase, ".bubble1"}, bubbleCnt1, expBubble[1]);
  endtask

  task automatic stepCycle(input string phase);
    @(posedge clk);
    modelStep();
    #1;
    checkAll(phase);
  endtask

  initial begin
    logic [DW-1:0] p;
    int rnd;
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) stepCycle("reset");
    checkOutput("reset.data0_zero", data0, '0);

    // Release reset with a load already presented.
    p = '0;
    p[0 +: WIDTH]     = 32'h8C020004;
    p[WIDTH +: WIDTH] = 32'h00003004;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p);
    #1 reset = 1'b1;
    stepCycle("load");
    checkOutput("load.valid", valid0, 1'b1);
    checkOutput("load.f0", data0[0 +: WIDTH], 32'h8C020004);
    checkOutput("load.f1", data0[WIDTH +: WIDTH], 32'h00003004);
    checkOutput("load.cnt", {stallCnt0, bubbleCnt0}, 8'h00);

    // Hold-mode and bubble-mode stall behaviour.
    p = '0;
    p[0 +: WIDTH] = 32'h12345678;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p);
    stepCycle("load2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, randPayload());
      stepCycle("stall");
      if (i == 0) begin
        checkOutput("bubmode.valid", valid1, 1'b0);
        checkOutput("bubmode.data", data1, '0);
        checkOutput("bubmode.stall", stallCnt1, 16'd1);
        checkOutput("bubmode.bubble", bubbleCnt1, 16'd1);
      end
    end
    checkOutput("hold.f0", data0[0 +: WIDTH], 32'h12345678);
    checkOutput("hold.valid", valid0, 1'b1);
    checkOutput("hold.stall", stallCnt0, 4'd3);
    checkOutput("hold.bubble", bubbleCnt0, 4'd0);

    // Flush wins over stall.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, randPayload());
    stepCycle("flush");
    checkOutput("flush.valid", valid0, 1'b0);
    checkOutput("flush.data", data0, '0);
    checkOutput("flush.stall", stallCnt0, 4'd3);
    checkOutput("flush.bubble", bubbleCnt0, 4'd1);

    // Saturation of the 4-bit counter, then clear overriding a stall.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randPayload());
      stepCycle("sat");
    end
    checkOutput("sat.stall", stallCnt0, 4'd15);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    stepCycle("clear");
    checkOutput("clear.stall", stallCnt0, 4'd0);

    // Asynchronous reset while stalled on a held value.
    p = '0;
    p[0 +: WIDTH] = 32'hDEADBEEF;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p);
    stepCycle("deadload");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, randPayload());
    stepCycle("deadstall");
    checkOutput("deadstall.f0", data0[0 +: WIDTH], 32'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("arst.data", data0, '0);
    checkOutput("arst.valid", valid0, 1'b0);
    checkOutput("arst.cnt", {stallCnt0, bubbleCnt0}, 8'h00);
    checkAll("arst");
    #2 reset = 1'b1;

    // Randomised traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7), randPayload());
      stepCycle("rand");
      rnd = $urandom_range(0, 49);
      if (rnd == 0) begin
        #2 reset = 1'b0;
        #1;
        modelReset();
        checkAll("randrst");
        #2 reset = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage core.
- Generalises the fixed per-stage register: configurable field count and width, explicit valid bit, separate flush and stall controls, and a per-instance stall mode (hold or bubble).
- Built-in saturating stall/bubble counters for hazard-unit performance debug.
- One instance sits between each pair of stages (F/D, D/E, E/M, M/W).

Parameters:
- WIDTH, 32, width of one payload field in bits.
- FIELDS, 6, number of payload fields carried (instr, PC, data1..3, ext).
- STALL_MODE, 0, 0 = hold contents on stall (decode-side use); 1 = insert bubble on stall (execute-side use).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  stall request from the hazard unit.
- flush  input  1  clear request (branch/exception kill).
- clear_stats  input  1  synchronous clear of both counters.
- valid_i  input  1  incoming slot holds a real instruction.
- data_i  input  FIELDS*WIDTH  packed payload; field k occupies bits [k*WIDTH +: WIDTH].
- valid_o  output  1  registered valid.
- data_o  output  FIELDS*WIDTH  registered payload.
- stall_cnt  output  CNT_W  cycles spent stalled.
- bubble_cnt  output  CNT_W  invalid slots loaded.

Behaviour:
- Reset asynchronous on the falling edge of reset, held while reset=0. Reset values: valid_o=0, data_o=0, stall_cnt=0, bubble_cnt=0.
- Latency: 1 cycle; a load is visible on data_o/valid_o after the capturing edge.
- Per-edge priority, evaluated at the rising clk edge with reset=1:
  - 1. flush=1: valid_o<=0, data_o<=0. This is a "bubble load".
  - 2. stall=1, STALL_MODE=0: valid_o and data_o hold.
  - 3. stall=1, STALL_MODE=1: valid_o<=0, data_o<=0. This is a bubble load.
  - 4. Otherwise, if valid_i=1: valid_o<=1, data_o<=data_i.
  - 5. Otherwise, valid_i=0: valid_o<=0, data_o<=0. Invalid payload is never propagated; zero payload is a nop. This is a bubble load.
- flush and stall together: flush wins in both modes.
- stall_cnt: +1 on each edge with stall=1 and flush=0, in either mode.
- bubble_cnt: +1 on each bubble load (cases 1, 3, 5).
- Counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats=1: both counters <=0 on that edge, overriding any same-edge increment. Pipeline state is unaffected.
- Counters reflect only edges where reset=1.
- Reset asserted mid-stall or mid-flush: everything returns to reset values immediately.
- After reset is released, the first edge behaves per the priority rules above. No stall is remembered across reset.
- data_o fields are independent slices; no field-specific treatment.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset then load: reset=0 for 2 cycles, release; valid_i=1, data_i field0=0x8C020004, field1=0x00003004 -> after 1 edge valid_o=1, field0=0x8C020004, field1=0x00003004; counters 0.
- Hold mode stall: STALL_MODE=0, loaded 0x12345678, stall=1 for 3 edges with data_i changing -> data_o stays 0x12345678, valid_o=1, stall_cnt=3, bubble_cnt=0.
- Bubble mode stall: STALL_MODE=1, loaded value, stall=1 for 1 edge -> valid_o=0, data_o=0, stall_cnt=1, bubble_cnt=1.
- Flush beats stall: STALL_MODE=0, stall=1 and flush=1 on one edge -> valid_o=0, data_o=0, stall_cnt unchanged, bubble_cnt+1.
- Counter saturation and clear: CNT_W=4, stall=1 for 20 edges -> stall_cnt=15. Then clear_stats=1 with stall=1 on one edge -> stall_cnt=0.
- Async reset mid-operation: stall held, data_o=0xDEADBEEF, drop reset between clock edges -> data_o=0, valid_o=0, counters 0 before the next edge.
